// File: rtl/toy_mem_arbiter.sv
// toy_mem_arbiter: shares one memory port between fetch and data, with a fetch starvation guard and a read-return tag pipe
module toy_mem_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [29:0] I_ADDR,
    output logic        I_GNT,
    output logic        I_VALID,
    output logic [31:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_RW,
    input  logic [29:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_VALID,
    output logic [31:0] D_RDATA,
    output logic        M_REQ,
    output logic        M_RW,
    output logic [29:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic        M_READY,
    input  logic [31:0] M_RDATA,
    output logic [15:0] CONFLICTS
);
    logic [3:0] starve_cnt;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_i;
    logic sel_i;
    logic gnt;
    logic rd_gnt;

    // >= keeps fetch selected while a forced grant is held off by M_READY
    assign sel_i     = I_REQ && (!D_REQ || (STARVE_MAX != 0 && starve_cnt >= 4'(STARVE_MAX)));
    assign M_REQ     = (I_REQ || D_REQ) && !RST;
    assign gnt       = M_REQ && M_READY;
    assign I_GNT     = gnt && sel_i;
    assign D_GNT     = gnt && !sel_i;
    assign M_RW      = !sel_i && D_RW;
    assign M_ADDR    = sel_i ? I_ADDR : D_ADDR;
    assign M_WDATA   = D_WDATA;
    assign rd_gnt    = I_GNT || (D_GNT && !D_RW);
    assign I_VALID   = !RST && tag_v[RD_LAT-1] && tag_i[RD_LAT-1];
    assign D_VALID   = !RST && tag_v[RD_LAT-1] && !tag_i[RD_LAT-1];
    assign I_RDATA   = M_RDATA;
    assign D_RDATA   = M_RDATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
            tag_v      <= '0;
            tag_i      <= '0;
            CONFLICTS  <= '0;
        end else begin
            starve_cnt <= (I_REQ && !I_GNT) ? starve_cnt + {3'b0, starve_cnt != 4'hF} : '0;
            for (int k = RD_LAT - 1; k > 0; k--) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            tag_v[0]   <= rd_gnt;
            tag_i[0]   <= I_GNT;
            CONFLICTS  <= CONFLICTS + {15'b0, I_REQ && D_REQ && CONFLICTS != 16'hFFFF};
        end
    end
endmodule

// File: tb/tb_toy_mem_arbiter.sv
// tb_toy_mem_arbiter: scoreboard bench with a behavioural arbiter/memory model
module tb_toy_mem_arbiter;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 3;

    logic        CLK = 0;
    logic        RST = 1;
    logic        I_REQ = 0;
    logic [29:0] I_ADDR = '0;
    logic        D_REQ = 0;
    logic        D_RW = 0;
    logic [29:0] D_ADDR = '0;
    logic [31:0] D_WDATA = '0;
    logic        M_READY = 1;
    logic [31:0] M_RDATA = '0;
    logic        I_GNT, I_VALID, D_GNT, D_VALID, M_REQ, M_RW;
    logic [31:0] I_RDATA, D_RDATA, M_WDATA;
    logic [29:0] M_ADDR;
    logic [15:0] CONFLICTS;

    toy_mem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
        .M_READY(M_READY), .M_RDATA(M_RDATA), .CONFLICTS(CONFLICTS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        bit          own_i;
        logic [31:0] data;
    } ret_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    ret_t sbq[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] env_mem [logic [29:0]];
    logic [31:0] ret_data [int];
    int streak = 0;
    int conf = 0;
    bit exp_ig = 0;
    bit exp_dg = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] seed_val(logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_rd(logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Memory side: accepts whatever the bus presents and returns read data RD_LAT cycles later
    always @(negedge CLK) begin
        if (M_REQ && M_READY) begin
            if (M_RW) env_mem[M_ADDR] = M_WDATA;
            else ret_data[cyc + RD_LAT] = env_mem.exists(M_ADDR) ? env_mem[M_ADDR] : seed_val(M_ADDR);
        end
    end

    always @(negedge CLK) begin : monitor
        bit   force_i, sel_i, req, ev;
        ret_t e;
        exp_ig = 0;
        exp_dg = 0;
        if (RST) begin
            chk("rst_m_req", 32'(M_REQ), 32'd0);
            chk("rst_i_gnt", 32'(I_GNT), 32'd0);
            chk("rst_d_gnt", 32'(D_GNT), 32'd0);
            chk("rst_i_valid", 32'(I_VALID), 32'd0);
            chk("rst_d_valid", 32'(D_VALID), 32'd0);
            chk("rst_conflicts", 32'(CONFLICTS), 32'(conf));
            sbq.delete();
            streak = 0;
            conf = 0;
        end else begin
            force_i = STARVE_MAX != 0 && streak >= STARVE_MAX;
            sel_i   = I_REQ && (!D_REQ || force_i);
            req     = I_REQ || D_REQ;
            exp_ig  = req && M_READY && sel_i;
            exp_dg  = req && M_READY && !sel_i;
            chk("m_req", 32'(M_REQ), 32'(req));
            chk("i_gnt", 32'(I_GNT), 32'(exp_ig));
            chk("d_gnt", 32'(D_GNT), 32'(exp_dg));
            chk("conflicts", 32'(CONFLICTS), 32'(conf));
            if (req) begin
                chk("m_addr", 32'(M_ADDR), 32'(sel_i ? I_ADDR : D_ADDR));
                chk("m_rw", 32'(M_RW), 32'(!sel_i && D_RW));
                if (!sel_i && D_RW) chk("m_wdata", M_WDATA, D_WDATA);
            end
            ev = sbq.size() > 0 && sbq[0].due == cyc;
            if (ev || I_VALID || D_VALID) begin
                if (!ev) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid cyc=%0d got i=%b d=%b want none", cyc, I_VALID, D_VALID);
                end else begin
                    e = sbq.pop_front();
                    chk("i_valid", 32'(I_VALID), 32'(e.own_i));
                    chk("d_valid", 32'(D_VALID), 32'(!e.own_i));
                    chk("rdata", e.own_i ? I_RDATA : D_RDATA, e.data);
                end
            end
            if (exp_ig) sbq.push_back('{cyc + RD_LAT, 1'b1, ref_rd(I_ADDR)});
            if (exp_dg && D_RW) ref_mem[D_ADDR] = D_WDATA;
            else if (exp_dg) sbq.push_back('{cyc + RD_LAT, 1'b0, ref_rd(D_ADDR)});
            streak = (I_REQ && !exp_ig) ? (streak < 15 ? streak + 1 : 15) : 0;
            if (I_REQ && D_REQ && conf < 65535) conf++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        M_RDATA = ret_data.exists(cyc) ? ret_data[cyc] : $urandom();
    endtask

    task automatic idle(int n);
        I_REQ = 0;
        D_REQ = 0;
        repeat (n) step();
    endtask

    initial begin
        env_mem[30'h10] = 32'hDEADBEEF;
        ref_mem[30'h10] = 32'hDEADBEEF;
        // Reset held two cycles under contention, then data wins first
        I_REQ = 1; I_ADDR = 30'h1; D_REQ = 1; D_RW = 0; D_ADDR = 30'h2;
        step(); step();
        RST = 0;
        step();
        D_REQ = 0;
        step();
        idle(4);
        // Solo fetch returning DEADBEEF
        I_REQ = 1; I_ADDR = 30'h10;
        step();
        idle(4);
        // Continuous contention: data, data, data, forced fetch, data
        I_REQ = 1; I_ADDR = 30'h4; D_REQ = 1; D_RW = 0; D_ADDR = 30'h5;
        repeat (5) step();
        idle(4);
        // Write, fetch read, data read back-to-back
        D_REQ = 1; D_RW = 1; D_ADDR = 30'h7; D_WDATA = 32'hCAFE_0007;
        step();
        D_REQ = 0; I_REQ = 1; I_ADDR = 30'h3;
        step();
        I_REQ = 0; D_REQ = 1; D_RW = 0; D_ADDR = 30'h7;
        step();
        idle(4);
        // Backpressure past the starvation limit, fetch goes first when ready
        M_READY = 0; I_REQ = 1; I_ADDR = 30'h8; D_REQ = 1; D_RW = 0; D_ADDR = 30'h9;
        repeat (6) step();
        M_READY = 1;
        step(); step();
        idle(4);
        // Reset while a fetch read is in flight
        I_REQ = 1; I_ADDR = 30'h10;
        step();
        I_REQ = 0; RST = 1;
        step();
        RST = 0;
        idle(4);
        // Randomized traffic with occasional resets
        repeat (2000) begin
            if (!I_REQ || exp_ig) begin
                I_REQ = $urandom_range(0, 2) != 0;
                I_ADDR = 30'($urandom_range(0, 15));
            end
            if (!D_REQ || exp_dg) begin
                D_REQ = $urandom_range(0, 2) != 0;
                D_RW = $urandom_range(0, 2) == 0;
                D_ADDR = 30'($urandom_range(0, 15));
                D_WDATA = $urandom();
            end
            M_READY = $urandom_range(0, 3) != 0;
            RST = $urandom_range(0, 199) == 0;
            step();
        end
        RST = 0;
        M_READY = 1;
        idle(RD_LAT + 2);
        // Long contention run to saturate CONFLICTS
        M_READY = 0; I_REQ = 1; D_REQ = 1; D_RW = 0;
        repeat (65540) step();
        M_READY = 1;
        idle(RD_LAT + 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
